ps2_rx_ctrl: RTL and testbench
==============================

PS2_RX_CTRL -- requirements
Module: ps2_rx_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: scancode FIFO entries, power of two, 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 5000: clk cycles without a ps2Clk falling edge before a partial frame is abandoned.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ps2Clk  input  1  raw PS/2 clock from keyboard, asynchronous to clk.
REQ-006 ps2Data  input  1  raw PS/2 data from keyboard, asynchronous to clk.
REQ-007 rdEn  input  1  one-cycle processor LDR strobe; pops the FIFO head and clears sticky flags.
REQ-008 rdData  output  32  status/data word: [7:0] FIFO head, [8] valid (FIFO non-empty), [9] overflow (sticky), [10] parity error (sticky), [31:11] zero.

Function
REQ-009 ps2Clk and ps2Data SHALL each pass through a 2-flop synchronizer; a sample event is a 1->0 transition of synchronized ps2Clk.
REQ-010 FSM states IDLE, DATA, PARITY, STOP; sampling occurs only on sample events.
REQ-011 IDLE: sampled data 0 (start bit) -> DATA, bit counter cleared; sampled data 1 -> stay IDLE.
REQ-012 DATA: shift sampled bit in LSB-first; after the 8th bit -> PARITY.
REQ-013 PARITY: capture bit -> STOP.
REQ-014 STOP: sampled data 1 and frame accepted per REQ-024 -> push byte; any other case -> drop byte; always -> IDLE.
REQ-015 In any state other than IDLE, a cycle counter resets on each sample event; reaching TIMEOUT_CYCLES -> IDLE, byte discarded, no flag set.
REQ-016 A pushed byte SHALL appear on rdData[7:0] with rdData[8]=1 in the first cycle after the clk edge that samples the stop bit.
REQ-017 rdData SHALL be combinational from FIFO head and flag registers; with FIFO empty, rdData[7:0]=0 and rdData[8]=0.
REQ-018 rdEn with FIFO non-empty pops one entry at that clk edge; rdEn with FIFO empty is ignored for the FIFO.
REQ-019 Push while full without a same-cycle pop: byte dropped, overflow set; FIFO contents unchanged.
REQ-020 Same-cycle push and pop while full: pop then push, no overflow; same-cycle push and pop while empty: byte stored, pop ignored.
REQ-021 rdEn clears overflow and parity error; a set and a clear in the same cycle leave the flag set.
REQ-022 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter distinguishes full from empty.

Reset
REQ-023 Reset low asynchronously forces FSM IDLE, counters 0, FIFO empty, flags 0, synchronizers 1, so rdData=0x0000_0000, including mid-frame; the first frame after release is received normally.

Configuration
REQ-024 Macro PS2_PARITY_CHECK_EN defined: odd parity over data+parity bit is checked; a mismatch drops the byte and sets rdData[10]. Undefined: parity bit captured but ignored, rdData[10] tied 0.

Structure
REQ-025 Package ps2_pkg holds the FSM state enum, rdData bit-index constants (VALID_BIT=8, OVF_BIT=9, PERR_BIT=10) and the data-bit count constant (8).
REQ-026 The FIFO SHALL be sub-module ps2_fifo (parameterized width/depth, push/pop/full/empty/head); FSM, synchronizers, timeout and flags stay in ps2_rx_ctrl.

Verification
REQ-027 Frame 0x1C with parity 0, stop 1 -> rdData=0x0000_011C; one rdEn -> rdData=0x0000_0000.
REQ-028 With PS2_PARITY_CHECK_EN: frame 0x1C with parity 1 -> no push, rdData=0x0000_0400; rdEn -> 0x0000_0000.
REQ-029 Five frames 0x01..0x05, no reads, depth 4 -> rdData=0x0000_0301; four rdEn yield heads 0x01..0x04, then rdData=0x0000_0000.
REQ-030 Start bit plus 3 data bits, then 5000 idle cycles -> FSM IDLE, no push, no flags; a following frame 0xF0 -> rdData=0x0000_01F0.
REQ-031 Reset pulsed low after 4 data bits with 2 bytes queued -> rdData=0x0000_0000 immediately; next frame 0x5A -> rdData=0x0000_015A.
REQ-032 FIFO full (0x11..0x14), rdEn in the same cycle as the stop-bit sample of 0x15 -> no overflow; drained heads 0x12, 0x13, 0x14, 0x15.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ps2_pkg;

    // Receive FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_e;

    // Bit positions within the processor status/data word.
    localparam int VALID_BIT = 8;
    localparam int OVF_BIT   = 9;
    localparam int PERR_BIT  = 10;

    // Data bits per PS/2 frame.
    localparam int DATA_BITS = 8;

    // Odd parity holds when data plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS:0] frame);
        return ^frame;
    endfunction

endpackage

// File: rtl/ps2_rx_ctrl_if.sv
// Bus bundle between a processor/keyboard side and the PS/2 receive controller.
// Latency: n/a (wiring only).
// Backpressure: none; rdEn is a single-cycle strobe, rdData is always valid.
//
// Signals:
//   ps2Clk, ps2Data : raw keyboard lines, asynchronous to the system clock
//   rdEn            : one-cycle read strobe (pops FIFO head, clears sticky flags)
//   rdData          : 32-bit status/data word
interface ps2_rx_ctrl_if;
    logic        ps2Clk;
    logic        ps2Data;
    logic        rdEn;
    logic [31:0] rdData;

    modport master (
        output ps2Clk,
        output ps2Data,
        output rdEn,
        input  rdData
    );

    modport slave (
        input  ps2Clk,
        input  ps2Data,
        input  rdEn,
        output rdData
    );
endinterface

// File: rtl/ps2_fifo.sv
// Small synchronous FIFO holding received scancodes; head is shown combinationally.
// Latency: a push is visible at head_o in the cycle after the pushing edge.
// Backpressure: none upstream; push while full (no pop) is dropped, pop while empty ignored.
//
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   push_i, push_dat_i  : write strobe and byte
//   pop_i               : read strobe
//   full_o, empty_o     : occupancy status
//   head_o              : oldest entry, zero when empty
module ps2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4     // power of two, 2..16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));

    // A pop frees a slot first, so a push into a full FIFO with a same-cycle
    // pop is accepted; a pop on an empty FIFO never happens, even with a push.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // Pointers are PW bits wide, so DEPTH being a power of two gives the wrap.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only observable once counted in.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receiver: synchronizes ps2Clk/ps2Data, deframes 11-bit frames, queues scancodes.
// Latency: byte on rdData the cycle after the clk edge that samples the stop bit (3 clk after ps2Clk falls).
// Backpressure: none; bytes arriving with the FIFO full are dropped and flag overflow.
//
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   bus    : ps2_rx_ctrl_if.slave (ps2Clk, ps2Data, rdEn in; rdData out)
//            rdData = {21'b0, parity_err, overflow, valid, head[7:0]}
//
// Build option: define PS2_PARITY_CHECK_EN to reject frames failing odd parity
// and report them in rdData[10]; otherwise the parity bit is ignored and bit 10 reads 0.
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic   clk,
    input  logic   reset,
    ps2_rx_ctrl_if.slave bus
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    // Synchronizers and falling-edge detect.
    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       clk_prev_q;
    logic       sample_evt;
    logic       sample_bit;

    // Frame FSM state.
    state_e             state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS:0] shift_q, shift_d;   // data bits then parity, LSB first
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;

    logic       push_vld;
    logic       frame_ok;
    logic       ovf_q, ovf_d;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic [31:0] rd_dat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], bus.ps2Clk};
            dat_sync_q <= {dat_sync_q[0], bus.ps2Data};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign sample_evt = clk_prev_q & ~clk_sync_q[1];
    assign sample_bit = dat_sync_q[1];

`ifdef PS2_PARITY_CHECK_EN
    logic perr_q, perr_d;
    logic perr_set;
    assign frame_ok = odd_parity_ok(shift_q);
    // Reported on any completed frame with bad parity, whatever the stop bit.
    assign perr_set = (state_q == ST_STOP) & sample_evt & ~frame_ok;
`else
    assign frame_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        to_cnt_d  = '0;
        push_vld  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (sample_evt && !sample_bit) begin
                state_d   = ST_DATA;
                bit_cnt_d = '0;
            end
        end else if (sample_evt) begin
            case (state_q)
                ST_DATA: begin
                    shift_d   = {sample_bit, shift_q[DATA_BITS:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    // Final shift leaves data in [7:0] and parity in [8].
                    shift_d = {sample_bit, shift_q[DATA_BITS:1]};
                    state_d = ST_STOP;
                end
                default: begin
                    push_vld = sample_bit & frame_ok;
                    state_d  = ST_IDLE;
                end
            endcase
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // Keyboard went quiet mid-frame: abandon silently.
            state_d = ST_IDLE;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    ps2_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push_vld),
        .push_dat_i (shift_q[7:0]),
        .pop_i      (bus.rdEn),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (fifo_head)
    );

    // Sticky flags: a set in the same cycle as a read-clear wins.
    always_comb begin
        ovf_d = (ovf_q & ~bus.rdEn) | (push_vld & fifo_full & ~bus.rdEn);
    end

`ifdef PS2_PARITY_CHECK_EN
    always_comb begin
        perr_d = (perr_q & ~bus.rdEn) | perr_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        rd_dat            = '0;
        rd_dat[7:0]       = fifo_head;
        rd_dat[VALID_BIT] = ~fifo_empty;
        rd_dat[OVF_BIT]   = ovf_q;
`ifdef PS2_PARITY_CHECK_EN
        rd_dat[PERR_BIT]  = perr_q;
`endif
    end

    assign bus.rdData = rd_dat;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Self-checking bench for ps2_rx_ctrl: directed frame scenarios plus a randomized
// scoreboard run where a monitor drains every valid byte against an expected queue.
// Latency/backpressure: exercised through full-FIFO, overflow and timeout scenarios.
module tb_ps2_rx_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    ps2_rx_ctrl_if bus();

    logic rd_dir = 1'b0;
    logic rd_mon = 1'b0;
    logic mon_en = 1'b0;
    assign bus.rdEn = rd_dir | rd_mon;

    ps2_rx_ctrl #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (5000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One PS/2 bit: data settles while the line clock is high, then clock low/high.
    // With rd_at_fall, rdEn is asserted for exactly the clk edge at which the
    // receiver acts on this falling edge (two synchronizer flops plus edge detect).
    task automatic send_bit(input logic b, input bit rd_at_fall);
        bus.ps2Data = b;
        repeat (4) @(negedge clk);
        bus.ps2Clk = 1'b0;
        if (rd_at_fall) begin
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            rd_dir = 1'b1;
            @(negedge clk);
            rd_dir = 1'b0;
            repeat (6) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
        bus.ps2Clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Start bit, nbits data bits; a complete frame (nbits==8) adds odd parity
    // (optionally inverted) and the given stop bit.
    task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit stop,
                              input int nbits, input bit rd_at_stop);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            send_bit(d[i], 1'b0);
        end
        if (nbits == 8) begin
            send_bit((~^d) ^ flip_par, 1'b0);
            send_bit(stop, rd_at_stop);
        end
        bus.ps2Data = 1'b1;
    endtask

    task automatic pulse_rd();
        @(negedge clk);
        rd_dir = 1'b1;
        @(negedge clk);
        rd_dir = 1'b0;
    endtask

    // Monitor: whenever a byte is valid, compare it with the scoreboard head and read it.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rd_mon) begin
                rd_mon = 1'b0;
            end else if (mon_en && bus.rdData[8] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("mon_spurious", bus.rdData, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_byte", {bus.rdData[31:11], 2'b00, bus.rdData[8:0]},
                          {21'b0, 2'b00, 1'b1, e});
                end
                rd_mon = 1'b1;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bit bad_stop;
        bit bad_par;

        reset = 1'b0;
        bus.ps2Clk = 1'b1;
        bus.ps2Data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_low", bus.rdData, 32'h0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", bus.rdData, 32'h0);

        // Single good frame then read.
        send_frame(8'h1C, 1'b0, 1'b1, 8, 1'b0);
        check("frame_1c", bus.rdData, 32'h0000_011C);
        pulse_rd();
        check("frame_1c_read", bus.rdData, 32'h0);

        // Wrong parity bit.
        send_frame(8'h1C, 1'b1, 1'b1, 8, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        check("parity_err", bus.rdData, 32'h0000_0400);
`else
        check("parity_ignored", bus.rdData, 32'h0000_011C);
`endif
        pulse_rd();
        check("parity_read", bus.rdData, 32'h0);

        // Overflow: five frames into a four-deep FIFO.
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0, 1'b1, 8, 1'b0);
        end
        check("ovf_full", bus.rdData, 32'h0000_0301);
        for (int i = 1; i <= 4; i++) begin
            pulse_rd();
            check("ovf_drain", bus.rdData, (i < 4) ? (32'h100 + 32'(i + 1)) : 32'h0);
        end

        // Partial frame abandoned by timeout, then a normal frame.
        send_frame(8'hA5, 1'b0, 1'b1, 3, 1'b0);
        repeat (5100) @(negedge clk);
        check("timeout_idle", bus.rdData, 32'h0);
        send_frame(8'hF0, 1'b0, 1'b1, 8, 1'b0);
        check("after_timeout", bus.rdData, 32'h0000_01F0);
        pulse_rd();
        check("after_timeout_read", bus.rdData, 32'h0);

        // Reset mid-frame with bytes queued.
        send_frame(8'hA1, 1'b0, 1'b1, 8, 1'b0);
        send_frame(8'hB2, 1'b0, 1'b1, 8, 1'b0);
        check("two_queued", bus.rdData, 32'h0000_01A1);
        send_frame(8'h3C, 1'b0, 1'b1, 4, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_mid", bus.rdData, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1, 8, 1'b0);
        check("after_reset", bus.rdData, 32'h0000_015A);
        pulse_rd();
        check("after_reset_read", bus.rdData, 32'h0);

        // Full FIFO with a read coinciding with the stop-bit sample.
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h11 + 8'(i), 1'b0, 1'b1, 8, 1'b0);
        end
        check("full_head", bus.rdData, 32'h0000_0111);
        send_frame(8'h15, 1'b0, 1'b1, 8, 1'b1);
        check("full_rw", bus.rdData, 32'h0000_0112);
        for (int i = 0; i < 4; i++) begin
            pulse_rd();
            check("full_rw_drain", bus.rdData, (i < 3) ? (32'h113 + 32'(i)) : 32'h0);
        end

        // Randomized frames checked by the monitor.
        mon_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom);
            bad_stop = ($urandom_range(0, 4) == 0);
            bad_par  = ($urandom_range(0, 4) == 0);
            if (!bad_stop && !(PAR_EN && bad_par)) begin
                exp_q.push_back(d);
            end
            send_frame(d, bad_par, !bad_stop, 8, 1'b0);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        mon_en = 1'b0;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        pulse_rd();
        check("final_idle", bus.rdData, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
